// File: rtl/cmac_matmul_seq.sv
// Self-sequencing complex fixed-point matrix multiplier C = A x B.
// Streams (i,j,k) terms from two external ROMs through a product/sum/accumulate pipeline.
module cmac_matmul_seq #(
    parameter int NBIT     = 32,
    parameter int FRAC_IN  = 27,
    parameter int DIM      = 3,
    parameter int ACC_W    = 32,
    parameter int FRAC_ACC = 11,
    parameter int SAT      = 1,
    localparam int AW      = $clog2(2 * DIM * DIM),
    localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ena_i,
    input  logic                    start_i,
    output logic [AW-1:0]           ma_addr_re_o,
    output logic [AW-1:0]           ma_addr_im_o,
    output logic [AW-1:0]           mb_addr_re_o,
    output logic [AW-1:0]           mb_addr_im_o,
    input  logic signed [NBIT-1:0]  ma_re_i,
    input  logic signed [NBIT-1:0]  ma_im_i,
    input  logic signed [NBIT-1:0]  mb_re_i,
    input  logic signed [NBIT-1:0]  mb_im_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    res_valid_o,
    output logic signed [ACC_W-1:0] res_re_o,
    output logic signed [ACC_W-1:0] res_im_o,
    output logic [RW-1:0]           res_row_o,
    output logic [RW-1:0]           res_col_o,
    output logic                    ovf_o
);

    localparam int PF    = 2 * FRAC_IN - NBIT;
    localparam int SH    = PF - FRAC_ACC;
    localparam int SUM_W = NBIT + 1;
    localparam int AD_W  = SUM_W - SH;
    localparam int EXT_W = ((AD_W > ACC_W) ? AD_W : ACC_W) + 1;
    localparam logic [RW-1:0] LAST = RW'(DIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [AW-1:0] elem_addr(input logic [RW-1:0] r,
                                                 input logic [RW-1:0] c,
                                                 input logic          im);
        return AW'(2 * (int'(r) * DIM + int'(c)) + int'(im));
    endfunction

    function automatic logic signed [NBIT-1:0] prod_hi(input logic signed [NBIT-1:0] a,
                                                       input logic signed [NBIT-1:0] b);
        logic signed [2*NBIT-1:0] p;
        p = (2 * NBIT)'(a) * (2 * NBIT)'(b);
        return NBIT'(p >>> NBIT);
    endfunction

    function automatic logic signed [EXT_W-1:0] scale(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] t;
        t = s >>> SH;
        return EXT_W'(t);
    endfunction

    function automatic logic fits(input logic signed [EXT_W-1:0] v);
        return (&v[EXT_W-1:ACC_W-1]) || !(|v[EXT_W-1:ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [EXT_W-1:0] v);
        if (fits(v) || SAT == 0) return v[ACC_W-1:0];
        else if (v[EXT_W-1])     return {1'b1, {(ACC_W-1){1'b0}}};
        else                     return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    state_t        state_q, state_d;
    logic [RW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
    logic [1:0]    drain_q, drain_d;
    logic          issue;

    logic [AW-1:0] ma_re_addr_q, ma_im_addr_q, mb_re_addr_q, mb_im_addr_q;
    logic          vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
    logic          kfirst_p1_q, kfirst_p2_q, kfirst_p3_q;
    logic          klast_p1_q, klast_p2_q, klast_p3_q;
    logic [RW-1:0] row_p1_q, row_p2_q, row_p3_q;
    logic [RW-1:0] col_p1_q, col_p2_q, col_p3_q;

    logic signed [NBIT-1:0]  prod_rr_p2_q, prod_ii_p2_q, prod_ri_p2_q, prod_ir_p2_q;
    logic signed [SUM_W-1:0] sum_re_p3_q, sum_im_p3_q;

    logic signed [EXT_W-1:0] add_re, add_im, tot_re, tot_im;
    logic                    ovf_hit;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q;
    logic [RW-1:0]           res_row_q, res_col_q;
    logic                    res_vld_q, ovf_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        drain_d = drain_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    issue   = 1'b1;
                end
            end
            S_RUN: begin
                if (i_q == LAST && j_q == LAST && k_q == LAST) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    issue = 1'b1;
                    if (k_q != LAST) begin
                        k_d = k_q + 1'b1;
                    end else begin
                        k_d = '0;
                        if (j_q != LAST) begin
                            j_d = j_q + 1'b1;
                        end else begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end
                    end
                end
            end
            // Four drain cycles flush the address, data, P and S stages.
            S_DRAIN: begin
                if (drain_q == 2'd3) state_d = S_DONE;
                else                 drain_d = drain_q + 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issue stage: FSM, counters and ROM address registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            ma_re_addr_q <= '0;
            ma_im_addr_q <= '0;
            mb_re_addr_q <= '0;
            mb_im_addr_q <= '0;
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            vld_p3_q     <= 1'b0;
        end else if (ena_i) begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            vld_p0_q <= issue;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (issue) begin
                ma_re_addr_q <= elem_addr(i_d, k_d, 1'b0);
                ma_im_addr_q <= elem_addr(i_d, k_d, 1'b1);
                mb_re_addr_q <= elem_addr(k_d, j_d, 1'b0);
                mb_im_addr_q <= elem_addr(k_d, j_d, 1'b1);
            end
        end
    end

    // Data stage -> P stage -> S stage; tags ride alongside the operands
    always_ff @(posedge clk_i) begin
        if (ena_i) begin
            kfirst_p1_q  <= (k_q == '0);
            klast_p1_q   <= (k_q == LAST);
            row_p1_q     <= i_q;
            col_p1_q     <= j_q;

            prod_rr_p2_q <= prod_hi(ma_re_i, mb_re_i);
            prod_ii_p2_q <= prod_hi(ma_im_i, mb_im_i);
            prod_ri_p2_q <= prod_hi(ma_re_i, mb_im_i);
            prod_ir_p2_q <= prod_hi(ma_im_i, mb_re_i);
            kfirst_p2_q  <= kfirst_p1_q;
            klast_p2_q   <= klast_p1_q;
            row_p2_q     <= row_p1_q;
            col_p2_q     <= col_p1_q;

            sum_re_p3_q  <= SUM_W'(prod_rr_p2_q) - SUM_W'(prod_ii_p2_q);
            sum_im_p3_q  <= SUM_W'(prod_ri_p2_q) + SUM_W'(prod_ir_p2_q);
            kfirst_p3_q  <= kfirst_p2_q;
            klast_p3_q   <= klast_p2_q;
            row_p3_q     <= row_p2_q;
            col_p3_q     <= col_p2_q;
        end
    end

    always_comb begin
        add_re  = scale(sum_re_p3_q);
        add_im  = scale(sum_im_p3_q);
        tot_re  = kfirst_p3_q ? add_re : EXT_W'(acc_re_q) + add_re;
        tot_im  = kfirst_p3_q ? add_im : EXT_W'(acc_im_q) + add_im;
        ovf_hit = !fits(tot_re) || !fits(tot_im);
    end

    // A stage: accumulate, result strobe and sticky overflow
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            res_row_q <= '0;
            res_col_q <= '0;
            res_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (ena_i) begin
            res_vld_q <= vld_p3_q && klast_p3_q;
            if (vld_p3_q) begin
                acc_re_q <= clamp(tot_re);
                acc_im_q <= clamp(tot_im);
                if (klast_p3_q) begin
                    res_row_q <= row_p3_q;
                    res_col_q <= col_p3_q;
                end
            end
            if (state_q == S_IDLE && start_i) ovf_q <= 1'b0;
            else if (vld_p3_q && ovf_hit)     ovf_q <= 1'b1;
        end
    end

    // Strobes are held through a stall and only shown on an advancing cycle.
    assign res_valid_o  = res_vld_q && ena_i;
    assign done_o       = (state_q == S_DONE) && ena_i;
    assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ma_addr_re_o = ma_re_addr_q;
    assign ma_addr_im_o = ma_im_addr_q;
    assign mb_addr_re_o = mb_re_addr_q;
    assign mb_addr_im_o = mb_im_addr_q;
    assign res_re_o     = acc_re_q;
    assign res_im_o     = acc_im_q;
    assign res_row_o    = res_row_q;
    assign res_col_o    = res_col_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_cmac_matmul_seq.sv
// Directed bench for cmac_matmul_seq: default engine plus ACC_W=20 saturating and wrapping copies.
module tb_cmac_matmul_seq;

    localparam int AW = 5;
    localparam int RW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, start;
    logic [AW-1:0] a_re_addr, a_im_addr, b_re_addr, b_im_addr;
    logic [AW-1:0] u1_ar, u1_ai, u1_br, u1_bi, u2_ar, u2_ai, u2_br, u2_bi;
    logic [31:0] ma_re, ma_im, mb_re, mb_im;

    logic busy0, done0, vld0, ovf0;
    logic [31:0] re0, im0;
    logic [RW-1:0] row0, col0;
    logic busy1, done1, vld1, ovf1;
    logic [19:0] re1, im1;
    logic [RW-1:0] row1, col1;
    logic busy2, done2, vld2, ovf2;
    logic [19:0] re2, im2;
    logic [RW-1:0] row2, col2;

    cmac_matmul_seq u0 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .start_i(start),
        .ma_addr_re_o(a_re_addr), .ma_addr_im_o(a_im_addr),
        .mb_addr_re_o(b_re_addr), .mb_addr_im_o(b_im_addr),
        .ma_re_i(ma_re), .ma_im_i(ma_im), .mb_re_i(mb_re), .mb_im_i(mb_im),
        .busy_o(busy0), .done_o(done0), .res_valid_o(vld0),
        .res_re_o(re0), .res_im_o(im0), .res_row_o(row0), .res_col_o(col0), .ovf_o(ovf0)
    );

    cmac_matmul_seq #(.ACC_W(20), .SAT(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .start_i(start),
        .ma_addr_re_o(u1_ar), .ma_addr_im_o(u1_ai),
        .mb_addr_re_o(u1_br), .mb_addr_im_o(u1_bi),
        .ma_re_i(ma_re), .ma_im_i(ma_im), .mb_re_i(mb_re), .mb_im_i(mb_im),
        .busy_o(busy1), .done_o(done1), .res_valid_o(vld1),
        .res_re_o(re1), .res_im_o(im1), .res_row_o(row1), .res_col_o(col1), .ovf_o(ovf1)
    );

    cmac_matmul_seq #(.ACC_W(20), .SAT(0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .start_i(start),
        .ma_addr_re_o(u2_ar), .ma_addr_im_o(u2_ai),
        .mb_addr_re_o(u2_br), .mb_addr_im_o(u2_bi),
        .ma_re_i(ma_re), .ma_im_i(ma_im), .mb_re_i(mb_re), .mb_im_i(mb_im),
        .busy_o(busy2), .done_o(done2), .res_valid_o(vld2),
        .res_re_o(re2), .res_im_o(im2), .res_row_o(row2), .res_col_o(col2), .ovf_o(ovf2)
    );

    // Shared synchronous ROMs; all three engines receive identical control so addresses agree.
    logic [31:0] romA [0:31];
    logic [31:0] romB [0:31];
    always @(posedge clk) begin
        ma_re <= romA[a_re_addr];
        ma_im <= romA[a_im_addr];
        mb_re <= romB[b_re_addr];
        mb_im <= romB[b_im_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n0 = 0;
    int nd = 0;
    int          r_cyc [0:127];
    logic [RW-1:0] r_row [0:127];
    logic [RW-1:0] r_col [0:127];
    logic [31:0] r_re [0:127];
    logic [31:0] r_im [0:127];
    logic [31:0] s_re [0:127];
    logic [31:0] s_im [0:127];
    logic [31:0] w_re [0:127];
    int          d_cyc [0:31];

    always @(negedge clk) begin
        if (vld0 && n0 < 128) begin
            r_cyc[n0] = cyc;
            r_row[n0] = row0;
            r_col[n0] = col0;
            r_re[n0]  = re0;
            r_im[n0]  = im0;
            s_re[n0]  = {12'h0, re1};
            s_im[n0]  = {12'h0, im1};
            w_re[n0]  = {12'h0, re2};
            n0++;
        end
        if (done0 && nd < 32) begin
            d_cyc[nd] = cyc;
            nd++;
        end
    end

    int total = 0;
    int bad   = 0;
    int c0 = 0;
    int b0 = 0;
    int bd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic go();
        start = 1'b1;
        c0 = cyc;
        b0 = n0;
        bd = nd;
        step();
        start = 1'b0;
    endtask

    task automatic run_to(input int rel);
        while (cyc < c0 + rel) step();
    endtask

    task automatic load_ident();
        for (int idx = 0; idx < 9; idx++) begin
            romA[2*idx]   = ((idx / 3) == (idx % 3)) ? 32'h0800_0000 : 32'h0;
            romA[2*idx+1] = 32'h0;
            romB[2*idx]   = 32'((idx + 1) * 134217728);
            romB[2*idx+1] = 32'(-idx * 67108864);
        end
    endtask

    task automatic load_all(input logic [31:0] re, input logic [31:0] im);
        for (int idx = 0; idx < 9; idx++) begin
            romA[2*idx]   = re;
            romA[2*idx+1] = im;
            romB[2*idx]   = re;
            romB[2*idx+1] = im;
        end
    endtask

    // With A = I the product equals B: re = (idx+1)*1.0, im = -idx*0.5 in Q21.11.
    task automatic check_ident(input string tag, input bit stall);
        int ec;
        chk({tag, "_count"}, 32'(n0 - b0), 32'd9);
        for (int n = 0; n < 9; n++) begin
            ec = 7 + 3 * n;
            if (stall && ec >= 13) ec += 5;
            chk({tag, "_cyc"}, 32'(r_cyc[b0+n] - c0), 32'(ec));
            chk({tag, "_row"}, 32'(r_row[b0+n]), 32'(n / 3));
            chk({tag, "_col"}, 32'(r_col[b0+n]), 32'(n % 3));
            chk({tag, "_re"}, r_re[b0+n], 32'((n + 1) * 2048));
            chk({tag, "_im"}, r_im[b0+n], 32'(-n * 1024));
        end
        chk({tag, "_done_cnt"}, 32'(nd - bd), 32'd1);
        chk({tag, "_done_cyc"}, 32'(d_cyc[bd] - c0), stall ? 32'd37 : 32'd32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        load_ident();
        for (int a = 18; a < 32; a++) begin
            romA[a] = 32'h0;
            romB[a] = 32'h0;
        end
        step();
        step();
        sample();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_ma_addr", 32'(a_re_addr), 32'd0);
        chk("rst_mb_addr_im", 32'(b_im_addr), 32'd0);
        chk("rst_res_re", re0, 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Identity run with address and timing spot checks
        go();
        sample();
        chk("c1_busy", 32'(busy0), 32'd1);
        chk("c1_ma_re", 32'(a_re_addr), 32'd0);
        chk("c1_ma_im", 32'(a_im_addr), 32'd1);
        chk("c1_mb_re", 32'(b_re_addr), 32'd0);
        step();
        sample();
        chk("c2_ma_re", 32'(a_re_addr), 32'd2);
        chk("c2_mb_re", 32'(b_re_addr), 32'd6);
        chk("c2_mb_im", 32'(b_im_addr), 32'd7);
        run_to(31);
        sample();
        chk("c31_busy", 32'(busy0), 32'd1);
        chk("c31_valid", 32'(vld0), 32'd1);
        step();
        sample();
        chk("c32_done", 32'(done0), 32'd1);
        chk("c32_busy", 32'(busy0), 32'd0);
        run_to(40);
        check_ident("ident", 1'b0);
        chk("ident_ovf", 32'(ovf0), 32'd0);

        // All entries 1+j: each term is 2j, three terms give 6j
        load_all(32'h0800_0000, 32'h0800_0000);
        go();
        run_to(40);
        chk("onej_count", 32'(n0 - b0), 32'd9);
        for (int n = 0; n < 9; n++) begin
            chk("onej_re", r_re[b0+n], 32'h0);
            chk("onej_im", r_im[b0+n], 32'h3000);
        end
        chk("onej_ovf", 32'(ovf0), 32'd0);

        // Near full-scale: each term adds 0x7FFFF; 20-bit accumulators overflow
        load_all(32'h7FFF_FFFF, 32'h0);
        go();
        run_to(40);
        chk("sat_count", 32'(n0 - b0), 32'd9);
        for (int n = 0; n < 9; n++) begin
            chk("sat_re", s_re[b0+n], 32'h7FFFF);
            chk("sat_im", s_im[b0+n], 32'h0);
            chk("wrap_re", w_re[b0+n], 32'h7FFFD);
            chk("wide_re", r_re[b0+n], 32'h17FFFD);
        end
        chk("sat_ovf", 32'(ovf1), 32'd1);
        chk("wrap_ovf", 32'(ovf2), 32'd1);
        chk("wide_ovf", 32'(ovf0), 32'd0);
        go();
        sample();
        chk("sat_ovf_clr", 32'(ovf1), 32'd0);
        chk("wrap_ovf_clr", 32'(ovf2), 32'd0);
        run_to(40);

        // Five-cycle stall covering the strobe at cycle 13
        load_ident();
        go();
        run_to(13);
        ena = 1'b0;
        repeat (5) step();
        ena = 1'b1;
        run_to(45);
        check_ident("stall", 1'b1);

        // start pulses during RUN and during DONE are ignored
        go();
        run_to(10);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(32);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(50);
        check_ident("ignore", 1'b0);
        chk("ignore_busy", 32'(busy0), 32'd0);

        // Mid-run reset aborts: three results so far, no done
        go();
        run_to(15);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_valid", 32'(vld0), 32'd0);
        chk("abort_ma_addr", 32'(a_re_addr), 32'd0);
        chk("abort_mb_addr_im", 32'(b_im_addr), 32'd0);
        chk("abort_res_re", re0, 32'd0);
        run_to(45);
        chk("abort_count", 32'(n0 - b0), 32'd3);
        chk("abort_done_cnt", 32'(nd - bd), 32'd0);

        // Clean rerun, then a back-to-back start in the cycle after done
        go();
        run_to(33);
        check_ident("rerun", 1'b0);
        go();
        sample();
        chk("b2b_busy", 32'(busy0), 32'd1);
        run_to(40);
        chk("b2b_count", 32'(n0 - b0), 32'd9);
        chk("b2b_done_cnt", 32'(nd - bd), 32'd1);
        chk("b2b_done_cyc", 32'(d_cyc[bd] - c0), 32'd32);
        chk("b2b_last_re", r_re[b0+8], 32'(9 * 2048));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
